// File: rtl/regfile_sb.sv
// Register file with per-register issue scoreboard, same-cycle write bypass and flush.
// Reads are combinational; write/alloc/flush land at the next edge; issue is throttled only via alloc_ok.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic                 alloc_ok,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy_vec,
  output logic [AW:0]          pending_cnt
);
  localparam logic [AW:0] DEPTH = (AW+1)'(NREGS);

  // Register 0 has no storage: it reads 0 and can never be busy.
  logic [XLEN-1:0]  r_regs [1:NREGS-1];
  logic [NREGS-1:1] r_busy;
  logic [AW:0]      r_cnt;

  logic [NREGS-1:1] w_busy_nxt;
  logic [AW:0]      w_cnt_nxt;
  logic             w_alloc_busy;
  logic             w_alloc_wr_hit;
  logic             w_alloc_valid;

  // Out-of-range addresses match no loop index, so they read 0 and are never busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int i = 1; i < NREGS; i++) begin
        if (rd_addr[p*AW +: AW] == AW'(i)) begin
          if ((BYPASS != 0) && wr_en && (wr_addr == AW'(i))) begin
            rd_data[p*XLEN +: XLEN] = wr_data;
          end else begin
            rd_data[p*XLEN +: XLEN] = r_regs[i];
            rd_busy[p]              = r_busy[i];
          end
        end
      end
    end
  end

  always_comb begin
    w_alloc_busy = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (alloc_addr == AW'(i)) w_alloc_busy = r_busy[i];
    end
  end

  assign w_alloc_wr_hit = wr_en && (wr_addr == alloc_addr);
  assign w_alloc_valid  = ({1'b0, alloc_addr} < DEPTH);
  assign alloc_ok       = alloc_en && !flush && w_alloc_valid && (!w_alloc_busy || w_alloc_wr_hit);

  // Priority: writeback clears, accepted alloc re-sets, flush clears everything.
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (wr_en && (wr_addr == AW'(i)))       w_busy_nxt[i] = 1'b0;
      if (alloc_ok && (alloc_addr == AW'(i))) w_busy_nxt[i] = 1'b1;
      if (flush)                              w_busy_nxt[i] = 1'b0;
      w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) r_regs[i] <= wr_data;
      end
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy_vec    = {r_busy, 1'b0};
  assign pending_cnt = r_cnt;

endmodule
